// File: rtl/aes_spi_pkg.sv
// Shared types and elaboration helpers for the AES SPI slave front end.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_CORE,
        HOLD,
        UNLOAD
    } spi_state_t;

    localparam int KEY_W_LEGAL[3] = '{128, 192, 256};

    // Counter must reach the saturation value B+K+1.
    function automatic int cnt_w(input int b, input int k);
        return $clog2(b + k + 2);
    endfunction

    function automatic bit key_w_ok(input int k);
        for (int unsigned i = 0; i < 3; i++) begin
            if (KEY_W_LEGAL[i] == k) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous input, with registered
// previous value to produce single-clk rise/fall pulses.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the raw pin through the synchroniser and remember the last synced value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/aes_spi_frontend.sv
// SPI mode-0 slave front end for the AES core: loads {intext,key}, starts the
// core, captures its result and shifts it back out on miso in a later frame.
module aes_spi_frontend
    import aes_spi_pkg::*;
#(
    parameter int K           = 128,
    parameter int B           = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    output logic [K-1:0] key,
    output logic [B-1:0] intext,
    output logic         start,
    input  logic         done,
    input  logic [B-1:0] outtext,
    output logic         ready,
    output logic         frame_err
);

    localparam int             CW         = cnt_w(B, K);
    localparam logic [CW-1:0]  LOAD_LEN   = CW'(B + K);
    localparam logic [CW-1:0]  CNT_SAT    = CW'(B + K + 1);
    localparam logic [CW-1:0]  UNLOAD_LEN = CW'(B);

    generate
        if (!key_w_ok(K)) begin : g_bad_key_w
            $error("aes_spi_frontend: K=%0d is not a legal key width (128/192/256)", K);
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("aes_spi_frontend: SYNC_STAGES=%0d must be >= 2", SYNC_STAGES);
        end
    endgenerate

    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_rise;
    logic       cs_fall;
    logic       mosi_level;
    logic [1:0] unused_levels;
    logic [1:0] unused_mosi_edges;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (sclk),
        .level   (unused_levels[0]),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    // cs_n idles high, so its synchroniser resets high to avoid a false fall.
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (cs_n),
        .level   (unused_levels[1]),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (mosi),
        .level   (mosi_level),
        .rise    (unused_mosi_edges[0]),
        .fall    (unused_mosi_edges[1])
    );

    spi_state_t       state;
    logic [CW-1:0]    count;
    logic [B+K-1:0]   load_sr;
    logic [B-1:0]     result;
    logic [B-1:0]     out_sr;
    logic [CW-1:0]    count_inc;

    assign count_inc = (count == CNT_SAT) ? count : count + 1'b1;

    assign key    = load_sr[K-1:0];
    assign intext = load_sr[B+K-1:K];

    // Frame FSM: bit counting, load/unload shifting, start/ready/frame_err and miso.
    // cs_n edges are tested before sclk edges so a coincident sclk edge is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            load_sr   <= '0;
            result    <= '0;
            out_sr    <= '0;
            start     <= 1'b0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            miso      <= 1'b0;
        end else begin
            start <= 1'b0;
            miso  <= 1'b0;
            unique case (state)
                IDLE, HOLD: begin
                    if (cs_fall) begin
                        count <= '0;
                        if (ready) begin
                            out_sr <= result;
                            miso   <= result[B-1];
                            state  <= UNLOAD;
                        end else begin
                            frame_err <= 1'b0;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (cs_rise) begin
                        if (count == LOAD_LEN) begin
                            start <= 1'b1;
                            state <= WAIT_CORE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        load_sr <= {load_sr[B+K-2:0], mosi_level};
                        count   <= count_inc;
                    end
                end
                WAIT_CORE: begin
                    if (done) begin
                        result <= outtext;
                        ready  <= 1'b1;
                        state  <= HOLD;
                    end
                end
                UNLOAD: begin
                    if (cs_rise) begin
                        if (count >= UNLOAD_LEN) begin
                            ready <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= HOLD;
                        end
                    end else begin
                        if (sclk_rise) begin
                            count <= count_inc;
                        end
                        // Zeros shift in behind the data, so miso reads 0 past bit B.
                        if (sclk_fall) begin
                            out_sr <= {out_sr[B-2:0], 1'b0};
                            miso   <= out_sr[B-2];
                        end else begin
                            miso   <= out_sr[B-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
